fadd_single_seq: RTL and testbench
==================================

Name: fadd_single_seq

Overview:
- Multi-cycle IEEE-754 single-precision adder; computes c = a + b.
- Complements the combinational subtractor in the floating-point library.
- Handles both effective addition and effective subtraction, with round-to-nearest-even.
- Valid/ready handshakes on input and output; one operation in flight; iterative one-bit-per-cycle normalisation.

Parameters:
- QNAN, 32'h7FC0_0000, canonical NaN returned for invalid operations and NaN inputs.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a, b valid.
- in_ready  output  1  block idle, can accept an operation.
- a  input  32  operand A, IEEE single.
- b  input  32  operand B, IEEE single.
- out_valid  output  1  result c valid.
- out_ready  input  1  consumer accepts the result.
- c  output  32  result, IEEE single.
- ovf  output  1  overflow flag, valid with out_valid.
- inv  output  1  invalid flag (NaN input or inf-inf), valid with out_valid.

Behaviour:
- Reset (async, immediate, any state): state=IDLE, in_ready=1, out_valid=0, c=0, ovf=0, inv=0. Any operation in flight is discarded.
- Accept: operands are captured at the edge where state=IDLE and in_valid=1. in_ready=1 only in IDLE.
- FSM states: IDLE -> ALIGN -> ADD -> NORM (1+k cycles) -> ROUND -> OUT -> IDLE.
- ALIGN:
  - Swap so that |A| >= |B| (compare exponent, then fraction).
  - Build 28-bit working mantissas: [27] carry=0, [26] hidden=1, [25:3] fraction, [2:0] guard/round/sticky=0.
  - Right-shift B by d = ea - eb. Bits shifted past [0] OR into sticky [0]. d >= 27 makes B = sticky only.
  - Result sign = sign of larger-magnitude operand. Exponent = ea.
- Special cases, decided in ALIGN; these go straight to OUT, so out_valid appears 2 cycles after accept:
  - Any NaN input, or +inf + -inf: c=QNAN, inv=1.
  - Any inf otherwise: c = that inf.
  - Denormal inputs (exp=0) are treated as signed zero.
  - Both zero: c = -0 only if both operands are -0, else +0.
  - Exactly one operand zero: c = the other operand.
- ADD: same signs -> sum = A + B. Different signs -> sum = A - B (never negative after the swap).
- NORM, one action per cycle:
  - sum==0: result +0, go to OUT.
  - sum[27]=1: shift right 1 (old [0] ORs into sticky), exp+1, go to ROUND.
  - sum[26]=1: go to ROUND.
  - Otherwise: shift left 1, exp-1, stay in NORM. If exp reaches 0, flush to signed zero and go to OUT.
- ROUND (RNE):
  - g=[2], r=[1], s=[0]; round up when g & (r | s | [3]).
  - A mantissa carry from rounding shifts right and does exp+1.
  - exp >= 255 -> c = signed inf, ovf=1.
- OUT:
  - out_valid=1; c, ovf, inv held stable until out_ready=1.
  - On the transfer edge: out_valid=0, state=IDLE.
  - No operation is accepted in the same cycle as a transfer.
- Latency: normal path out_valid rises 5+k cycles after the accept edge, where k = number of left normalisation shifts (0..25). Special path: 2 cycles.
- Flags clear when a new operation is accepted.

Test Plan:
- 0x3F800000 + 0x40000000 (1.0 + 2.0) -> c=0x40400000, ovf=inv=0, out_valid 5 cycles after accept.
- 0x3FC00000 + 0xBFA00000 (1.5 - 1.25) -> c=0x3E800000, k=2, out_valid 7 cycles after accept. Also 0x3F800000 + 0xBF800000 -> c=0x00000000.
- Rounding:
  - 0x3F800000 + 0x33800000 (tie, even LSB) -> c=0x3F800000.
  - 0x3F800000 + 0x34400000 (tie, odd LSB) -> c=0x3F800002.
- 0x7F7FFFFF + 0x7F7FFFFF -> c=0x7F800000, ovf=1.
- 0x7F800000 + 0xFF800000 -> c=0x7FC00000, inv=1, out_valid 2 cycles after accept.
- Hold and reset:
  - Keep out_ready=0 for 10 cycles -> c stable, in_ready=0.
  - Assert rst during NORM of a cancellation case -> out_valid=0 and in_ready=1 immediately.
  - A following operation completes correctly.

Source files
------------

// File: rtl/fadd_single_seq.sv
// +--------------------------------------------------------------------------+
// | fadd_single_seq: multi-cycle IEEE-754 single adder, RNE, valid/ready.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module fadd_single_seq #(
  parameter logic [31:0] QNAN = 32'h7FC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] c,
  output logic        ovf,
  output logic        inv
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ALIGN = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_NORM  = 3'd3;
  localparam logic [2:0] S_ROUND = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;

  logic [2:0]  r_state;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [27:0] r_ma;
  logic [27:0] r_mb;
  logic [27:0] r_sum;
  logic [8:0]  r_exp;
  logic        r_sign;
  logic        r_sub;
  logic [31:0] r_c;
  logic        r_ovf;
  logic        r_inv;
  logic        r_out_valid;

  // Operand classification; exponent 0 (zero or denormal) counts as zero.
  logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  assign w_a_zero = (r_a[30:23] == 8'd0);
  assign w_b_zero = (r_b[30:23] == 8'd0);
  assign w_a_inf  = (r_a[30:23] == 8'hFF) && (r_a[22:0] == 23'd0);
  assign w_b_inf  = (r_b[30:23] == 8'hFF) && (r_b[22:0] == 23'd0);
  assign w_a_nan  = (r_a[30:23] == 8'hFF) && (r_a[22:0] != 23'd0);
  assign w_b_nan  = (r_b[30:23] == 8'hFF) && (r_b[22:0] != 23'd0);

  logic        w_swap;
  logic [31:0] w_big;
  logic [31:0] w_small;
  logic [7:0]  w_d;
  logic [27:0] w_mbig;
  logic [27:0] w_msmall;
  logic [27:0] w_mask;
  logic        w_sticky;
  logic [27:0] w_shifted;

  assign w_swap    = (r_b[30:0] > r_a[30:0]);
  assign w_big     = w_swap ? r_b : r_a;
  assign w_small   = w_swap ? r_a : r_b;
  assign w_d       = w_big[30:23] - w_small[30:23];
  assign w_mbig    = {2'b01, w_big[22:0], 3'b000};
  assign w_msmall  = {2'b01, w_small[22:0], 3'b000};
  assign w_mask    = (28'd1 << w_d) - 28'd1;
  assign w_sticky  = |(w_msmall & w_mask);
  // Beyond 26 positions the whole smaller mantissa collapses into sticky.
  assign w_shifted = (w_d >= 8'd27) ? 28'd1
                                    : ((w_msmall >> w_d) | {27'd0, w_sticky});

  logic        w_round_up;
  logic [24:0] w_mant_rnd;
  logic [8:0]  w_exp_rnd;
  logic [22:0] w_frac_rnd;

  assign w_round_up = r_sum[2] & (r_sum[1] | r_sum[0] | r_sum[3]);
  assign w_mant_rnd = {1'b0, r_sum[26:3]} + {24'd0, w_round_up};
  assign w_exp_rnd  = r_exp + {8'd0, w_mant_rnd[24]};
  assign w_frac_rnd = w_mant_rnd[24] ? w_mant_rnd[23:1] : w_mant_rnd[22:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= 32'd0;
      r_b         <= 32'd0;
      r_ma        <= 28'd0;
      r_mb        <= 28'd0;
      r_sum       <= 28'd0;
      r_exp       <= 9'd0;
      r_sign      <= 1'b0;
      r_sub       <= 1'b0;
      r_c         <= 32'd0;
      r_ovf       <= 1'b0;
      r_inv       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_ovf   <= 1'b0;
            r_inv   <= 1'b0;
            r_state <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          r_state <= S_OUT;
          if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (r_a[31] != r_b[31]))) begin
            r_c   <= QNAN;
            r_inv <= 1'b1;
          end else if (w_a_inf) begin
            r_c <= r_a;
          end else if (w_b_inf) begin
            r_c <= r_b;
          end else if (w_a_zero && w_b_zero) begin
            r_c <= {r_a[31] & r_b[31], 31'd0};
          end else if (w_a_zero) begin
            r_c <= r_b;
          end else if (w_b_zero) begin
            r_c <= r_a;
          end else begin
            r_ma    <= w_mbig;
            r_mb    <= w_shifted;
            r_sign  <= w_big[31];
            r_exp   <= {1'b0, w_big[30:23]};
            r_sub   <= r_a[31] ^ r_b[31];
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_sum   <= r_sub ? (r_ma - r_mb) : (r_ma + r_mb);
          r_state <= S_NORM;
        end
        S_NORM: begin
          if (r_sum == 28'd0) begin
            r_c     <= 32'd0;
            r_state <= S_OUT;
          end else if (r_sum[27]) begin
            r_sum   <= {1'b0, r_sum[27:2], r_sum[1] | r_sum[0]};
            r_exp   <= r_exp + 9'd1;
            r_state <= S_ROUND;
          end else if (r_sum[26]) begin
            r_state <= S_ROUND;
          end else begin
            r_sum <= {r_sum[26:0], 1'b0};
            r_exp <= r_exp - 9'd1;
            // Underflow into the denormal range flushes to signed zero.
            if (r_exp == 9'd1) begin
              r_c     <= {r_sign, 31'd0};
              r_state <= S_OUT;
            end
          end
        end
        S_ROUND: begin
          if (w_exp_rnd >= 9'd255) begin
            r_c   <= {r_sign, 8'hFF, 23'd0};
            r_ovf <= 1'b1;
          end else begin
            r_c <= {r_sign, w_exp_rnd[7:0], w_frac_rnd};
          end
          r_state <= S_OUT;
        end
        S_OUT: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign c         = r_c;
  assign ovf       = r_ovf;
  assign inv       = r_inv;

endmodule

`default_nettype wire

// File: tb/tb_fadd_single_seq.sv
// +--------------------------------------------------------------------------+
// | tb_fadd_single_seq: scoreboard bench with exact-arithmetic reference.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_fadd_single_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] c;
  logic        ovf;
  logic        inv;

  fadd_single_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .ovf       (ovf),
    .inv       (inv)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] c;
    logic        ovf;
    logic        inv;
    int          lat;
    longint      t_acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  bit   bp_mode = 1'b0;
  bit   hold_ready = 1'b1;
  bit   prev_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  // Exact sum with wide integers, then a single round-to-nearest-even.
  function automatic logic [33:0] ref_add(input logic [31:0] x, input logic [31:0] y);
    logic          sx, sy, sgn;
    int            ex, ey, e_hi, e_lo, p, sh, e_res;
    logic [22:0]   fx, fy;
    logic [299:0]  mx, my, s, rem, half, q;
    sx = x[31]; ex = int'(x[30:23]); fx = x[22:0];
    sy = y[31]; ey = int'(y[30:23]); fy = y[22:0];
    if ((ex == 255 && fx != 0) || (ey == 255 && fy != 0)) return {32'h7FC0_0000, 2'b01};
    if (ex == 255 && ey == 255 && sx != sy) return {32'h7FC0_0000, 2'b01};
    if (ex == 255) return {x, 2'b00};
    if (ey == 255) return {y, 2'b00};
    if (ex == 0 && ey == 0) return {sx & sy, 31'd0, 2'b00};
    if (ex == 0) return {y, 2'b00};
    if (ey == 0) return {x, 2'b00};
    if (y[30:0] > x[30:0]) begin
      sgn = sy; e_hi = ey; e_lo = ex;
      mx = {276'd0, 1'b1, fy}; my = {276'd0, 1'b1, fx};
    end else begin
      sgn = sx; e_hi = ex; e_lo = ey;
      mx = {276'd0, 1'b1, fx}; my = {276'd0, 1'b1, fy};
    end
    mx = mx << (e_hi - e_lo);
    s  = (sx == sy) ? (mx + my) : (mx - my);
    if (s == 0) return 34'd0;
    p = 0;
    for (int i = 299; i >= 0; i--) begin
      if (s[i]) begin p = i; break; end
    end
    e_res = e_lo + p - 23;
    if (e_res <= 0) return {sgn, 31'd0, 2'b00};
    if (p > 23) begin
      sh   = p - 23;
      q    = s >> sh;
      rem  = s & ((300'd1 << sh) - 300'd1);
      half = 300'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 300'd1;
      if (q[24]) begin q = q >> 1; e_res++; end
    end else begin
      q = s << (23 - p);
    end
    if (e_res >= 255) return {sgn, 8'hFF, 23'd0, 2'b10};
    return {sgn, e_res[7:0], q[22:0], 2'b00};
  endfunction

  // Monitor: latency on the rising edge of out_valid, data on each transfer.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_out_valid: got c=%h with no operation outstanding", c);
        end else if (sb[0].lat >= 0) begin
          check("latency", 64'(($time - sb[0].t_acc - 5) / 10), 64'(sb[0].lat));
        end
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        check("c", {32'd0, c}, {32'd0, e.c});
        check("ovf", {63'd0, ovf}, {63'd0, e.ovf});
        check("inv", {63'd0, inv}, {63'd0, e.inv});
      end
    end
    prev_valid = out_valid;
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = bp_mode ? 1'($urandom % 2) : hold_ready;
    end
  end

  task automatic issue(input logic [31:0] xa, input logic [31:0] xb, input int lat, input bit push);
    int          n;
    exp_t        e;
    logic [33:0] r;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 300 cycles");
      return;
    end
    a = xa; b = xb; in_valid = 1'b1;
    @(posedge clk);
    if (push) begin
      r       = ref_add(xa, xb);
      e.c     = r[33:2];
      e.ovf   = r[1];
      e.inv   = r[0];
      e.lat   = lat;
      e.t_acc = $time;
      sb.push_back(e);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      $display("FAIL drain_timeout: got %0d results outstanding expected 0", sb.size());
      sb.delete();
    end
  endtask

  function automatic logic [31:0] rand_op(input int e_hint);
    int r, e;
    r = int'($urandom_range(0, 99));
    if (r < 4)  return {1'($urandom % 2), 31'd0};
    if (r < 6)  return {1'($urandom % 2), 8'hFF, 23'd0};
    if (r < 8)  return {1'($urandom % 2), 8'hFF, 23'($urandom_range(1, 32'h7F_FFFF))};
    if (r < 10) return {1'($urandom % 2), 8'h00, 23'($urandom)};
    e = e_hint + int'($urandom_range(0, 60)) - 30;
    if (e < 1) e = 1;
    if (e > 254) e = 254;
    return {1'($urandom % 2), 8'(e), 23'($urandom)};
  endfunction

  initial begin
    logic [33:0] r;
    logic [31:0] ra, rb;
    int          eh, n;

    rst = 1'b1; in_valid = 1'b0; a = 32'd0; b = 32'd0;
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_c", {32'd0, c}, 64'd0);
    check("rst_ovf", {63'd0, ovf}, 64'd0);
    check("rst_inv", {63'd0, inv}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    issue(32'h3F80_0000, 32'h4000_0000, 5, 1'b1); wait_drain();
    issue(32'h3FC0_0000, 32'hBFA0_0000, 7, 1'b1); wait_drain();
    issue(32'h3F80_0000, 32'hBF80_0000, -1, 1'b1); wait_drain();
    issue(32'h3F80_0000, 32'h3380_0000, -1, 1'b1); wait_drain();
    issue(32'h3F80_0000, 32'h3440_0000, -1, 1'b1); wait_drain();
    issue(32'h7F7F_FFFF, 32'h7F7F_FFFF, -1, 1'b1); wait_drain();
    issue(32'h7F80_0000, 32'hFF80_0000, 2, 1'b1); wait_drain();
    issue(32'h7FC1_2345, 32'h3F80_0000, 2, 1'b1); wait_drain();
    issue(32'hFF80_0000, 32'h4120_0000, 2, 1'b1); wait_drain();
    issue(32'h8000_0000, 32'h8000_0000, 2, 1'b1); wait_drain();
    issue(32'h8000_0000, 32'h0000_0000, 2, 1'b1); wait_drain();
    issue(32'h0000_0001, 32'hBF80_0000, 2, 1'b1); wait_drain();
    issue(32'h8080_0001, 32'h0080_0000, -1, 1'b1); wait_drain();
    issue(32'h3F80_0000, 32'hB300_0000, -1, 1'b1); wait_drain();

    // Back-pressure: result must stay put while the consumer stalls.
    hold_ready = 1'b0;
    issue(32'h4049_0FDB, 32'h3F80_0000, -1, 1'b1);
    r = ref_add(32'h4049_0FDB, 32'h3F80_0000);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      check("hold_out_valid", {63'd0, out_valid}, 64'd1);
      check("hold_c", {32'd0, c}, {32'd0, r[33:2]});
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
      @(negedge clk);
    end
    hold_ready = 1'b1;
    wait_drain();

    // Reset in the middle of a long normalisation.
    issue(32'h3F80_0000, 32'hBF7F_FFFF, -1, 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("midrst_c", {32'd0, c}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(32'h3FC0_0000, 32'hBFA0_0000, 7, 1'b1); wait_drain();

    bp_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: eh = int'($urandom_range(1, 6));
        1: eh = int'($urandom_range(248, 254));
        default: eh = int'($urandom_range(1, 254));
      endcase
      ra = rand_op(eh);
      if ($urandom_range(0, 6) == 0)
        rb = {~ra[31], ra[30:0] ^ 31'($urandom_range(0, 15))};
      else
        rb = rand_op(eh);
      issue(ra, rb, -1, 1'b1);
    end
    wait_drain();
    bp_mode = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
